// File: rtl/hbram_cal_window_tuner_if.sv
// Control, test-engine handshake and result bundle for the HyperBus RAM capture-window tuner.
// The tuner connects through the slave modport; whatever drives start and runs the pattern tests uses master.
interface hbram_cal_window_tuner_if #(
    parameter int LANES = 2,
    parameter int STEPS = 8
);
    localparam int DLY_W = $clog2(STEPS);

    logic                         start;
    logic                         test_req;
    logic                         test_done;
    logic [LANES-1:0]             test_pass;
    logic [LANES*DLY_W-1:0]       dly_sel;
    logic                         busy;
    logic                         done;
    logic [LANES-1:0]             fail;
    logic [LANES*(DLY_W+1)-1:0]   win_len;

    modport master (
        output start, test_done, test_pass,
        input  test_req, dly_sel, busy, done, fail, win_len
    );

    modport slave (
        input  start, test_done, test_pass,
        output test_req, dly_sel, busy, done, fail, win_len
    );
endinterface

// File: rtl/hbram_cal_window_tuner.sv
// Sweeps a common delay tap across all byte lanes and parks each lane at the centre of its widest passing
// window. Build option HBRAM_CAL_RETRY_EN re-runs a failing sweep up to two more times before reporting fail.
module hbram_cal_window_tuner #(
    parameter int LANES      = 2,
    parameter int STEPS      = 8,
    parameter int SETTLE_CYC = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    hbram_cal_window_tuner_if.slave bus
);
    // state  | meaning
    // IDLE   | waiting for start; dly_sel holds the last published result
    // APPLY  | sweep tap driven on every lane, settle timer counting down
    // TEST   | test_req held high until the engine pulses test_done
    // EVAL   | latched pass bits folded into the run / best-window trackers
    // FINISH | best windows centred and published (or sweep restarted on retry)
    localparam int DLY_W = $clog2(STEPS);
    localparam logic [DLY_W-1:0] TAP_LAST    = DLY_W'(STEPS - 1);
    localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYC - 1);
    localparam logic [DLY_W:0]   LEN_ONE     = (DLY_W+1)'(1);

    typedef enum logic [2:0] {IDLE, APPLY, TEST, EVAL, FINISH} state_t;

    state_t state, state_nxt;

    logic [DLY_W-1:0] tap;
    logic [7:0]       settle_cnt;
    logic [LANES-1:0] pass_lat;
    logic [DLY_W:0]   run_len       [LANES];
    logic [DLY_W-1:0] run_start     [LANES];
    logic [DLY_W:0]   best_len      [LANES];
    logic [DLY_W-1:0] best_start    [LANES];
    logic [DLY_W:0]   run_len_nxt   [LANES];
    logic [DLY_W-1:0] run_start_nxt [LANES];
    logic [DLY_W-1:0] centre        [LANES];
    logic [DLY_W-1:0] dly_q         [LANES];
    logic [DLY_W:0]   win_q         [LANES];
    logic [LANES-1:0] fail_q;
    logic [LANES-1:0] no_win;
    logic             done_q;
    logic             last_tap;
    logic             sweep_init;
    logic             retry;

    assign last_tap   = (tap == TAP_LAST);
    assign sweep_init = (state == IDLE && bus.start) || (state == FINISH && retry);

`ifdef HBRAM_CAL_RETRY_EN
    logic [1:0] retry_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retry_cnt <= '0;
        else if (state == IDLE && bus.start)
            retry_cnt <= '0;
        else if (state == FINISH && retry)
            retry_cnt <= retry_cnt + 2'd1;
    end

    assign retry = (|no_win) && (retry_cnt != 2'd2);
`else
    assign retry = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = APPLY;
            APPLY:   if (settle_cnt == '0) state_nxt = TEST;
            TEST:    if (bus.test_done) state_nxt = EVAL;
            EVAL:    state_nxt = last_tap ? FINISH : APPLY;
            FINISH:  state_nxt = retry ? APPLY : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Centre uses the floor of (len-1)/2 so even-length windows lean toward the lower tap.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            run_len_nxt[i]   = pass_lat[i] ? run_len[i] + LEN_ONE : '0;
            run_start_nxt[i] = (pass_lat[i] && run_len[i] == '0) ? tap : run_start[i];
            centre[i]        = DLY_W'(({1'b0, best_start[i]} + ((best_len[i] - LEN_ONE) >> 1)));
            no_win[i]        = (best_len[i] == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap        <= '0;
            settle_cnt <= '0;
            pass_lat   <= '0;
            fail_q     <= '0;
            done_q     <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                run_len[i]    <= '0;
                run_start[i]  <= '0;
                best_len[i]   <= '0;
                best_start[i] <= '0;
                dly_q[i]      <= '0;
                win_q[i]      <= '0;
            end
        end else begin
            if (state == IDLE && bus.start) begin
                done_q <= 1'b0;
                fail_q <= '0;
                for (int i = 0; i < LANES; i++)
                    win_q[i] <= '0;
            end

            if (sweep_init) begin
                tap        <= '0;
                settle_cnt <= SETTLE_LOAD;
                for (int i = 0; i < LANES; i++) begin
                    run_len[i]    <= '0;
                    run_start[i]  <= '0;
                    best_len[i]   <= '0;
                    best_start[i] <= '0;
                    dly_q[i]      <= '0;
                end
            end

            if (state == APPLY && settle_cnt != '0)
                settle_cnt <= settle_cnt - 8'd1;

            if (state == TEST && bus.test_done)
                pass_lat <= bus.test_pass;

            // Strict compare keeps the earliest window when two are equally long.
            if (state == EVAL) begin
                for (int i = 0; i < LANES; i++) begin
                    run_len[i]   <= run_len_nxt[i];
                    run_start[i] <= run_start_nxt[i];
                    if (run_len_nxt[i] > best_len[i]) begin
                        best_len[i]   <= run_len_nxt[i];
                        best_start[i] <= run_start_nxt[i];
                    end
                end
                if (!last_tap) begin
                    tap        <= tap + DLY_W'(1);
                    settle_cnt <= SETTLE_LOAD;
                    for (int i = 0; i < LANES; i++)
                        dly_q[i] <= tap + DLY_W'(1);
                end
            end

            if (state == FINISH && !retry) begin
                for (int i = 0; i < LANES; i++) begin
                    dly_q[i] <= no_win[i] ? '0 : centre[i];
                    win_q[i] <= best_len[i];
                end
                fail_q <= no_win;
                done_q <= ~|no_win;
            end
        end
    end

    always_comb begin
        bus.dly_sel = '0;
        bus.win_len = '0;
        for (int i = 0; i < LANES; i++) begin
            bus.dly_sel[i*DLY_W +: DLY_W]         = dly_q[i];
            bus.win_len[i*(DLY_W+1) +: (DLY_W+1)] = win_q[i];
        end
    end

    assign bus.test_req = (state == TEST);
    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_q;
    assign bus.fail     = fail_q;
endmodule
